mips_lsu: RTL and testbench
===========================

Name: mips_lsu

Overview:
- Load/store unit sitting directly upstream of the data memory (MD) in the IMIPS datapath.
- Accepts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests from the MEM stage and converts them to word-indexed accesses on the memory's AM/DM_/EW/DM interface.
- Performs byte-lane extraction and sign/zero extension on loads, and read-modify-write for sub-word stores.
- Handshakes with the pipeline through a valid/ready request channel and a one-cycle response pulse.

Parameters:
- MEM_WORDS, 512, number of 32-bit words in the downstream memory; word indices >= MEM_WORDS are out of range.

Ports:
- clk  in  1  system clock; memory writes on negedge, LSU registers on posedge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept a request this cycle
- req_store  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualifies resp_valid: request faulted
- resp_rdata  out  32  extended load data (0 for stores and faults)
- mem_addr  out  32  word index to memory AM
- mem_wdata  out  32  write data to memory DM_
- mem_we  out  1  write enable to memory EW
- mem_rdata  in  32  combinational read data from memory DM

Behaviour:
- Byte order is little-endian: byte offset 0 maps to bits 7:0 and offset 3 to bits 31:24. Half offset 0 maps to bits 15:0 and offset 2 to bits 31:16.
- FSM states: IDLE, ACCESS, WRITE, RESP.
- req_ready = (state == IDLE). A request is accepted on a posedge with req_valid && req_ready, and all req_* fields are latched at that edge.
- Transitions:
  - IDLE -> ACCESS on accept.
  - ACCESS -> RESP for a load, word store, or fault.
  - ACCESS -> WRITE for SB/SH.
  - WRITE -> RESP.
  - RESP -> IDLE unconditionally.
- mem_addr = {2'b00, latched_addr[31:2]}; it is held for the whole transaction and holds its last value in IDLE.
- ACCESS, load: the selected lane is extracted from mem_rdata, extended, and registered into resp_rdata at the ACCESS->RESP edge.
- ACCESS, SW: mem_we = 1 and mem_wdata = req_wdata for the ACCESS cycle only, so memory writes on that cycle's negedge.
- ACCESS, SB/SH: mem_rdata is captured into an internal old-word register and mem_we = 0.
- WRITE: mem_wdata = old word with the target lane replaced by req_wdata[7:0] or req_wdata[15:0]; mem_we = 1 for this cycle only.
- RESP: resp_valid = 1 for exactly one cycle. resp_rdata and resp_err hold until the next RESP cycle.
- Latency from the accept edge: load/SW/fault respond in cycle +2; SB/SH respond in cycle +3. Throughput is one request per 3 (or 4) cycles, with no back-to-back accept.
- Faults (set resp_err, never assert mem_we, resp_rdata = 0):
  - req_size == 11.
  - latched_addr[31:2] >= MEM_WORDS.
- mem_we is combinationally gated by !rst, so no write can occur in a reset cycle.
- Reset (synchronous): state = IDLE; resp_valid, resp_err, resp_rdata, mem_addr, mem_wdata = 0; mem_we = 0.
- Reset in ACCESS or WRITE abandons the transaction with no memory write and no response.
- req_valid while not ready is ignored, not queued. The requester must hold the request until it is accepted.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0] = 1, or a word access with addr[1:0] != 0, is a fault. It goes ACCESS -> RESP with resp_err = 1, no mem_we, and resp_rdata = 0.
- Undefined: the offending low address bits are forced to zero (half aligned to 2, word aligned to 4) and the access proceeds normally with resp_err = 0.

Test Plan:
- Preload word 3 = 0x8899AABB. Load byte, signed, addr 0x0D -> resp_valid at accept+2, resp_rdata = 0xFFFFFFAA, resp_err = 0, mem_we never asserted.
- Same preload. Load half, unsigned, addr 0x0E -> resp_rdata = 0x00008899 at accept+2.
- SB req_wdata = 0x1234565A to addr 0x0C -> mem_we high only in cycle accept+2 with mem_wdata = 0x8899AA5A; resp_valid at accept+3. A following LW at 0x0C returns 0x8899AA5A.
- SW 0x12345678 to addr 0x10 -> mem_we only in cycle accept+1, mem_addr = 4; a following LW at 0x10 returns 0x12345678.
- Fault cases, no mem_we in any: LW at 0x800 (word 512) -> resp_err = 1, resp_rdata = 0. req_size = 11 -> resp_err = 1. LW at 0x0E: with LSU_MISALIGN_TRAP_EN, resp_err = 1; without it, returns word 3 (0x8899AABB).
- SH to 0x0C, rst asserted during the WRITE cycle -> mem_we stays 0, word 3 unchanged, no resp_valid, req_ready = 1 the cycle after reset deasserts.

Source files
------------

// File: rtl/mips_lsu.sv
// Load/store unit in front of the IMIPS data memory: byte-addressed LB..SW requests
// become word-indexed accesses with lane extraction and read-modify-write for SB/SH.
// Optional: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module mips_lsu #(
  parameter int unsigned MEM_WORDS = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] old_q, old_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        store_q, store_d;
  logic        signed_q, signed_d;
  logic [1:0]  size_q, size_d;

  logic        fault;
  logic [1:0]  off;
  logic [31:0] shifted;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic        we_c;
  logic        resp_valid_c;
  logic [31:0] mem_wdata_c;

  // Effective byte offset; misaligned low bits are dropped when not trapping.
  always_comb begin
    case (size_q)
      2'b00:   off = addr_q[1:0];
      2'b01:   off = {addr_q[1], 1'b0};
      default: off = 2'b00;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    fault = (size_q == 2'b11) || (addr_q[31:2] >= MEM_WORDS_W) ||
            ((size_q == 2'b01) && addr_q[0]) ||
            ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
`else
    fault = (size_q == 2'b11) || (addr_q[31:2] >= MEM_WORDS_W);
`endif
  end

  always_comb begin
    shifted = mem_rdata >> {off, 3'b000};
    case (size_q)
      2'b00:   load_ext = signed_q ? {{24{shifted[7]}}, shifted[7:0]}
                                   : {24'h000000, shifted[7:0]};
      2'b01:   load_ext = signed_q ? {{16{shifted[15]}}, shifted[15:0]}
                                   : {16'h0000, shifted[15:0]};
      default: load_ext = shifted;
    endcase
    merged = old_q;
    if (size_q == 2'b00) merged[{off, 3'b000} +: 8]       = wdata_q[7:0];
    else                 merged[{off[1], 4'b0000} +: 16]  = wdata_q[15:0];
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    old_d        = old_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    store_d      = store_q;
    signed_d     = signed_q;
    size_d       = size_q;
    we_c         = 1'b0;
    resp_valid_c = 1'b0;
    mem_wdata_c  = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          store_d  = req_store;
          signed_d = req_signed;
          size_d   = req_size;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (fault) begin
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
          state_d      = RESP;
        end else if (store_q) begin
          if (size_q == 2'b10) begin
            we_c         = 1'b1;
            mem_wdata_c  = wdata_q;
            resp_err_d   = 1'b0;
            resp_rdata_d = '0;
            state_d      = RESP;
          end else begin
            old_d   = mem_rdata;
            state_d = WRITE;
          end
        end else begin
          resp_err_d   = 1'b0;
          resp_rdata_d = load_ext;
          state_d      = RESP;
        end
      end
      WRITE: begin
        we_c         = 1'b1;
        mem_wdata_c  = merged;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        state_d      = RESP;
      end
      RESP: begin
        resp_valid_c = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      old_q        <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      store_q      <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      old_q        <= old_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      store_q      <= store_d;
      signed_q     <= signed_d;
      size_q       <= size_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_c & ~rst;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = {2'b00, addr_q[31:2]};
  assign mem_we     = we_c & ~rst;
  assign mem_wdata  = rst ? '0 : mem_wdata_c;

endmodule

// File: tb/tb_mips_lsu.sv
// Directed self-checking bench for mips_lsu with a behavioural negedge-write memory.
module tb_mips_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:511];
  int          n_checks = 0;
  int          n_errors = 0;
  int          we_total = 0;

  mips_lsu #(.MEM_WORDS(512)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 32'd512) ? mem[mem_addr[8:0]] : 32'h0;

  always @(negedge clk) begin
    if (mem_we) begin
      we_total = we_total + 1;
      if (mem_addr < 32'd512) mem[mem_addr[8:0]] = mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one request and watches cycles accept+1..accept+5 at the negedge.
  task automatic run_req(input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int resp_k, output int resp_cnt,
                         output int we_k, output int we_cnt,
                         output logic [31:0] rdata, output logic err,
                         output logic [31:0] we_data, output logic [31:0] we_addr);
    int guard;
    resp_k = 0; resp_cnt = 0; we_k = 0; we_cnt = 0;
    rdata = 'x; err = 1'bx; we_data = 'x; we_addr = 'x;
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        resp_cnt++;
        if (resp_k == 0) begin
          resp_k = k; rdata = resp_rdata; err = resp_err;
        end
      end
      if (mem_we) begin
        we_cnt++;
        we_k = k; we_data = mem_wdata; we_addr = mem_addr;
      end
    end
  endtask

  int          rk, rc, wk, wc;
  logic [31:0] rd, wdat, wadr;
  logic        er;

  initial begin
    for (int unsigned i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[3]   = 32'h8899AABB;
    mem[511] = 32'h01020304;
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);

    run_req(1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, rk, rc, wk, wc, rd, er, wdat, wadr);
    check("lb_resp_k", rk, 2);
    check("lb_resp_cnt", rc, 1);
    check("lb_rdata", rd, 32'hFFFFFFAA);
    check("lb_err", {31'b0, er}, 32'd0);
    check("lb_we_cnt", wc, 0);

    run_req(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, rk, rc, wk, wc, rd, er, wdat, wadr);
    check("lhu_resp_k", rk, 2);
    check("lhu_rdata", rd, 32'h00008899);

    run_req(1'b0, 2'b01, 1'b1, 32'h0C, 32'h0, rk, rc, wk, wc, rd, er, wdat, wadr);
    check("lh_signed_rdata", rd, 32'hFFFFAABB);

    run_req(1'b0, 2'b00, 1'b0, 32'h0F, 32'h0, rk, rc, wk, wc, rd, er, wdat, wadr);
    check("lbu_off3_rdata", rd, 32'h00000088);

    run_req(1'b0, 2'b10, 1'b0, 32'h0E, 32'h0, rk, rc, wk, wc, rd, er, wdat, wadr);
    check("lw_mis_resp_k", rk, 2);
    check("lw_mis_we_cnt", wc, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_mis_err", {31'b0, er}, 32'd1);
    check("lw_mis_rdata", rd, 32'h0);
`else
    check("lw_mis_err", {31'b0, er}, 32'd0);
    check("lw_mis_rdata", rd, 32'h8899AABB);
`endif

    run_req(1'b0, 2'b10, 1'b0, 32'h7FC, 32'h0, rk, rc, wk, wc, rd, er, wdat, wadr);
    check("lw_last_err", {31'b0, er}, 32'd0);
    check("lw_last_rdata", rd, 32'h01020304);

    run_req(1'b1, 2'b00, 1'b0, 32'h0C, 32'h1234565A, rk, rc, wk, wc, rd, er, wdat, wadr);
    check("sb_we_cnt", wc, 1);
    check("sb_we_k", wk, 2);
    check("sb_we_data", wdat, 32'h8899AA5A);
    check("sb_we_addr", wadr, 32'd3);
    check("sb_resp_k", rk, 3);
    check("sb_rdata", rd, 32'h0);
    check("sb_err", {31'b0, er}, 32'd0);

    run_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, rk, rc, wk, wc, rd, er, wdat, wadr);
    check("lw_after_sb", rd, 32'h8899AA5A);

    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, rk, rc, wk, wc, rd, er, wdat, wadr);
    check("sw_we_cnt", wc, 1);
    check("sw_we_k", wk, 1);
    check("sw_we_addr", wadr, 32'd4);
    check("sw_we_data", wdat, 32'h12345678);
    check("sw_resp_k", rk, 2);

    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rk, rc, wk, wc, rd, er, wdat, wadr);
    check("lw_after_sw", rd, 32'h12345678);

    run_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000CAFE, rk, rc, wk, wc, rd, er, wdat, wadr);
    check("sh_we_data", wdat, 32'hCAFE5678);
    check("sh_resp_k", rk, 3);

    run_req(1'b0, 2'b10, 1'b0, 32'h800, 32'h0, rk, rc, wk, wc, rd, er, wdat, wadr);
    check("oob_err", {31'b0, er}, 32'd1);
    check("oob_rdata", rd, 32'h0);
    check("oob_we_cnt", wc, 0);
    check("oob_resp_k", rk, 2);

    run_req(1'b1, 2'b11, 1'b0, 32'h0C, 32'hFFFFFFFF, rk, rc, wk, wc, rd, er, wdat, wadr);
    check("rsv_err", {31'b0, er}, 32'd1);
    check("rsv_we_cnt", wc, 0);
    check("rsv_resp_k", rk, 2);
    check("rsv_mem3", mem[3], 32'h8899AA5A);

    // SH interrupted by reset during its WRITE cycle.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 32'h0C; req_wdata = 32'h0000BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rstw_access_we", {31'b0, mem_we}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rstw_write_we", {31'b0, mem_we}, 32'd0);
    check("rstw_write_rv", {31'b0, resp_valid}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstw_ready", {31'b0, req_ready}, 32'd1);
    rc = 0; wc = we_total;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) rc++;
      @(negedge clk);
    end
    check("rstw_no_resp", rc, 0);
    check("rstw_no_we", we_total - wc, 0);
    check("rstw_mem3", mem[3], 32'h8899AA5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
